// File: rtl/instruction_fetch.sv
// ============================================================================
// Module   : instruction_fetch
// Purpose  : Fetch stage. Owns the word PC, drives a 1-cycle synchronous imem,
//            and hands inst/PC pairs to EX with stall hold and one-bubble
//            redirects.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module instruction_fetch #(
  parameter int               PC_W     = 12,
  parameter logic [PC_W-1:0]  RESET_PC = '0,
  parameter logic [31:0]      NOP_INST = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_EX,
  input  logic [1:0]      pc_sel_EX,
  input  logic [PC_W-1:0] branch_addr,
  input  logic [PC_W-1:0] jal_addr,
  input  logic [PC_W-1:0] jalr_addr,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     inst,
  output logic [PC_W-1:0] prog_counter_EX,
  output logic            valid_EX
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_f_q, pc_f_d;
  logic [PC_W-1:0] pc_ex_q, pc_ex_d;
  logic [31:0]     hold_inst_q, hold_inst_d;

  logic            redirect;
  logic [PC_W-1:0] target;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= BOOT;
      pc_f_q      <= RESET_PC;
      pc_ex_q     <= RESET_PC;
      hold_inst_q <= NOP_INST;
    end else begin
      state_q     <= state_d;
      pc_f_q      <= pc_f_d;
      pc_ex_q     <= pc_ex_d;
      hold_inst_q <= hold_inst_d;
    end
  end

  always_comb begin
    target = branch_addr;
    case (pc_sel_EX)
      2'b10:   target = jal_addr;
      2'b11:   target = jalr_addr;
      default: target = branch_addr;
    endcase
  end

  // valid_EX is zero in BOOT/FLUSH, so redirects are naturally ignored there.
  assign redirect = (pc_sel_EX != 2'b00) & valid_EX & ~stall_EX;

  always_comb begin
    state_d     = state_q;
    pc_f_d      = pc_f_q;
    pc_ex_d     = pc_ex_q;
    hold_inst_d = hold_inst_q;
    case (state_q)
      BOOT, FLUSH: begin
        if (!stall_EX) begin
          pc_ex_d = pc_f_q;
          pc_f_d  = pc_f_q + PC_W'(1);
          state_d = RUN;
        end
      end
      RUN, STALL: begin
        if (stall_EX) begin
          // Only the RUN->STALL edge captures; memory output moves on afterwards.
          if (state_q == RUN) begin
            hold_inst_d = imem_rdata;
            state_d     = STALL;
          end
        end else if (redirect) begin
          pc_f_d  = target;
          pc_ex_d = target;
          state_d = FLUSH;
        end else begin
          pc_ex_d = pc_f_q;
          pc_f_d  = pc_f_q + PC_W'(1);
          state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    inst     = NOP_INST;
    valid_EX = 1'b0;
    case (state_q)
      RUN: begin
        inst     = imem_rdata;
        valid_EX = 1'b1;
      end
      STALL: begin
        inst     = hold_inst_q;
        valid_EX = 1'b1;
      end
      default: begin
        inst     = NOP_INST;
        valid_EX = 1'b0;
      end
    endcase
  end

  assign imem_addr       = pc_f_q;
  assign prog_counter_EX = pc_ex_q;

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch.sv
// ============================================================================
// Module   : tb_instruction_fetch
// Purpose  : Directed plus randomized bench for instruction_fetch against a
//            sequence-level model of what EX should observe each cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_instruction_fetch;

  localparam int          PC_W = 12;
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [11:0] RPC  = 12'h000;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            stall_EX;
  logic [1:0]      pc_sel_EX;
  logic [PC_W-1:0] branch_addr, jal_addr, jalr_addr;
  logic [PC_W-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic [31:0]     inst;
  logic [PC_W-1:0] prog_counter_EX;
  logic            valid_EX;

  logic [31:0] mem [0:4095];
  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  instruction_fetch #(.PC_W(PC_W), .RESET_PC(RPC), .NOP_INST(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .stall_EX(stall_EX), .pc_sel_EX(pc_sel_EX),
    .branch_addr(branch_addr), .jal_addr(jal_addr), .jalr_addr(jalr_addr),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .inst(inst),
    .prog_counter_EX(prog_counter_EX), .valid_EX(valid_EX)
  );

  always #5 clk = ~clk;

  always @(posedge clk) imem_rdata <= mem[imem_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: what EX sees is either a bubble or the next word in program order;
  // a taken redirect replaces the next word with the target after one bubble.
  logic        m_valid;
  logic [11:0] m_pc, m_next;
  logic [11:0] m_tgt;

  always_comb begin
    m_tgt = branch_addr;
    if (pc_sel_EX == 2'b10) m_tgt = jal_addr;
    if (pc_sel_EX == 2'b11) m_tgt = jalr_addr;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_pc    <= RPC;
      m_next  <= RPC;
    end else if (!stall_EX) begin
      if (m_valid && pc_sel_EX != 2'b00) begin
        m_valid <= 1'b0;
        m_pc    <= m_tgt;
        m_next  <= m_tgt;
      end else begin
        m_valid <= 1'b1;
        m_pc    <= m_next;
        m_next  <= m_next + 12'd1;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_valid", {31'd0, valid_EX}, {31'd0, m_valid});
      chk("model_pc", {20'd0, prog_counter_EX}, {20'd0, m_pc});
      chk("model_inst", inst, m_valid ? mem[m_pc] : NOP);
      chk("model_imem_addr", {20'd0, imem_addr}, {20'd0, m_next});
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic expect_out(input string name, input logic v, input logic [11:0] pc);
    logic [31:0] want;
    want = v ? (32'h1000_0000 + {20'd0, pc}) : NOP;
    chk({name, "_valid"}, {31'd0, valid_EX}, {31'd0, v});
    chk({name, "_pc"}, {20'd0, prog_counter_EX}, {20'd0, pc});
    chk({name, "_inst"}, inst, want);
  endtask

  initial begin
    rst_n = 1'b0; stall_EX = 1'b0; pc_sel_EX = 2'b00;
    branch_addr = '0; jal_addr = '0; jalr_addr = '0;
    for (int i = 0; i < 4096; i++) mem[i] = 32'h1000_0000 + i;
    repeat (3) @(posedge clk);
    cmp_en = 1'b1;
    #2;
    expect_out("reset", 1'b0, RPC);
    chk("reset_imem_addr", {20'd0, imem_addr}, {20'd0, RPC});
    rst_n = 1'b1;

    // Boot then sequential run
    expect_out("boot", 1'b0, RPC);
    for (int i = 0; i < 6; i++) begin
      step();
      expect_out("seq", 1'b1, 12'(i));
    end

    // Stall at pc 5 for three cycles, no gap on release
    stall_EX = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      expect_out("stall_hold", 1'b1, 12'd5);
    end
    stall_EX = 1'b0;
    step(); expect_out("stall_release", 1'b1, 12'd6);
    step(); expect_out("pre_branch", 1'b1, 12'd7);

    // Branch, JAL, JALR each cost one bubble
    pc_sel_EX = 2'b01; branch_addr = 12'h020;
    step(); expect_out("br_bubble", 1'b0, 12'h020);
    pc_sel_EX = 2'b00;
    step(); expect_out("br_target", 1'b1, 12'h020);
    pc_sel_EX = 2'b10; jal_addr = 12'h100;
    step(); expect_out("jal_bubble", 1'b0, 12'h100);
    pc_sel_EX = 2'b00;
    step(); expect_out("jal_target", 1'b1, 12'h100);
    pc_sel_EX = 2'b11; jalr_addr = 12'h3FF;
    step(); expect_out("jalr_bubble", 1'b0, 12'h3FF);
    pc_sel_EX = 2'b00;
    step(); expect_out("jalr_target", 1'b1, 12'h3FF);

    // Redirect held under stall only takes effect on release
    pc_sel_EX = 2'b01; branch_addr = 12'h050; stall_EX = 1'b1;
    step(); expect_out("br_stall1", 1'b1, 12'h3FF);
    step(); expect_out("br_stall2", 1'b1, 12'h3FF);
    stall_EX = 1'b0;
    step(); expect_out("br_rel_bubble", 1'b0, 12'h050);
    pc_sel_EX = 2'b00;
    step(); expect_out("br_rel_target", 1'b1, 12'h050);

    // PC wrap
    pc_sel_EX = 2'b01; branch_addr = 12'hFFE;
    step(); expect_out("wrap_bubble", 1'b0, 12'hFFE);
    pc_sel_EX = 2'b00;
    step(); expect_out("wrap0", 1'b1, 12'hFFE);
    step(); expect_out("wrap1", 1'b1, 12'hFFF);
    step(); expect_out("wrap2", 1'b1, 12'h000);
    step(); expect_out("wrap3", 1'b1, 12'h001);

    // Reset mid-STALL
    stall_EX = 1'b1;
    step(); step();
    #3 rst_n = 1'b0;
    #1 expect_out("rst_stall", 1'b0, RPC);
    chk("rst_stall_imem_addr", {20'd0, imem_addr}, {20'd0, RPC});
    stall_EX = 1'b0;
    step();
    rst_n = 1'b1;
    expect_out("rst_stall_boot", 1'b0, RPC);
    step(); expect_out("rst_stall_seq0", 1'b1, 12'd0);
    step(); expect_out("rst_stall_seq1", 1'b1, 12'd1);

    // Reset mid-FLUSH
    pc_sel_EX = 2'b10; jal_addr = 12'h200;
    step(); expect_out("flush_bubble", 1'b0, 12'h200);
    pc_sel_EX = 2'b00;
    #3 rst_n = 1'b0;
    #1 expect_out("rst_flush", 1'b0, RPC);
    step();
    rst_n = 1'b1;
    expect_out("rst_flush_boot", 1'b0, RPC);
    step(); expect_out("rst_flush_seq0", 1'b1, 12'd0);
    step(); expect_out("rst_flush_seq1", 1'b1, 12'd1);

    // Randomized phase with fresh memory contents loaded under reset
    rst_n = 1'b0;
    for (int i = 0; i < 4096; i++) mem[i] = $urandom;
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      stall_EX    = ($urandom_range(0, 9) < 3);
      pc_sel_EX   = ($urandom_range(0, 9) < 3) ? 2'($urandom_range(1, 3)) : 2'b00;
      branch_addr = 12'($urandom);
      jal_addr    = 12'($urandom);
      jalr_addr   = 12'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end else begin
        step();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
